// File: rtl/data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// data_memory_arbiter
//
// Two-port arbiter/sequencer in front of a single-port data memory with
// synchronous write and combinational read. Port 0 (CPU MEM stage) has
// priority. Port 1 (loader/DMA/debug) is guaranteed service after at most
// STARVE_LIMIT consecutive port-0 grants made while it waits.
//
// Each granted request is latched and driven onto the memory for exactly one
// cycle (ACCESS). The following cycle (DONE) answers with a one-cycle ack
// pulse and registered read data. Misaligned addresses skip ACCESS and are
// answered with err set and zero read data.
//
// Ports
//   clk, reset              system clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}_i request inputs, held stable until the ack
//   ack/err/rdata{0,1}_o    completion pulse, misaligned flag, read data
//   mem_*_o, mem_data_i     connection to the data memory
//   busy_o                  high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module data_memory_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0
  input  logic                  req0_i,
  input  logic                  we0_i,
  input  logic [DATA_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  output logic                  ack0_o,
  output logic                  err0_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  // port 1
  input  logic                  req1_i,
  input  logic                  we1_i,
  input  logic [DATA_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  ack1_o,
  output logic                  err1_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  // memory side
  output logic [DATA_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_write_data_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // A 4-bit starvation counter cannot represent limits outside 1..15.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("data_memory_arbiter: STARVE_LIMIT=%0d outside legal range 1..15",
           STARVE_LIMIT);
  end

  state_t                  state_q, state_d;
  logic [3:0]              starve_q, starve_d;
  logic                    sel_q, sel_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;

  logic                    grant1;
  logic                    win_we;
  logic [DATA_WIDTH-1:0]   win_addr;
  logic [DATA_WIDTH-1:0]   win_wdata;
  logic                    mem_active;

  // Port 1 wins when alone, or when port 0 has already been served
  // STARVE_LIMIT times in a row while port 1 was waiting.
  assign grant1    = req1_i & (~req0_i | (starve_q == LIMIT));
  assign win_we    = grant1 ? we1_i    : we0_i;
  assign win_addr  = grant1 ? addr1_i  : addr0_i;
  assign win_wdata = grant1 ? wdata1_i : wdata0_i;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    sel_d    = sel_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (req0_i || req1_i) begin
          sel_d   = grant1;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;

          if (grant1 || !req1_i) begin
            starve_d = '0;
          end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 4'd1;
          end

          if (win_addr[1:0] != 2'b00) begin
            // Misaligned: answer directly, never touch the memory.
            err_d   = 1'b1;
            state_d = DONE;
            if (grant1) rdata1_d = '0;
            else        rdata0_d = '0;
          end else begin
            err_d   = 1'b0;
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        if (!we_q) begin
          if (sel_q) rdata1_d = mem_data_i;
          else       rdata0_d = mem_data_i;
        end
        state_d = DONE;
      end

      DONE: begin
        // Requests are ignored here; the requester's req is still high.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: the latched request and read-data registers are reset along with
  // the control state, so outputs are defined immediately after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= '0;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Memory strobes live only in ACCESS. The write strobe is gated by reset so
  // an aborted transaction can never commit.
  assign mem_write_o      = (state_q == ACCESS) & we_q & ~reset;
  assign mem_read_o       = (state_q == ACCESS) & ~we_q;
  assign mem_active       = mem_write_o | mem_read_o;
  assign mem_address_o    = mem_active ? addr_q  : '0;
  assign mem_write_data_o = mem_active ? wdata_q : '0;

  assign ack0_o   = (state_q == DONE) & ~sel_q;
  assign ack1_o   = (state_q == DONE) &  sel_q;
  assign err0_o   = ack0_o & err_q;
  assign err1_o   = ack1_o & err_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// -----------------------------------------------------------------------------
// tb_data_memory_arbiter
//
// Bench for data_memory_arbiter with a behavioural data memory attached.
// Expected responses are queued per port when a request is driven and checked
// by a monitor when the matching ack appears.
// -----------------------------------------------------------------------------
module tb_data_memory_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_i, we0_i, req1_i, we1_i;
  logic [DW-1:0] addr0_i, wdata0_i, addr1_i, wdata1_i;
  logic          ack0_o, err0_o, ack1_o, err1_o;
  logic [DW-1:0] rdata0_o, rdata1_o;
  logic [DW-1:0] mem_address_o, mem_write_data_o, mem_data_i;
  logic          mem_write_o, mem_read_o, busy_o;

  data_memory_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .req0_i           (req0_i),
    .we0_i            (we0_i),
    .addr0_i          (addr0_i),
    .wdata0_i         (wdata0_i),
    .ack0_o           (ack0_o),
    .err0_o           (err0_o),
    .rdata0_o         (rdata0_o),
    .req1_i           (req1_i),
    .we1_i            (we1_i),
    .addr1_i          (addr1_i),
    .wdata1_i         (wdata1_i),
    .ack1_o           (ack1_o),
    .err1_o           (err1_o),
    .rdata1_o         (rdata1_o),
    .mem_address_o    (mem_address_o),
    .mem_write_data_o (mem_write_data_o),
    .mem_write_o      (mem_write_o),
    .mem_read_o       (mem_read_o),
    .mem_data_i       (mem_data_i),
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  // Behavioural Data_Memory: synchronous write, combinational read.
  logic [DW-1:0] env_mem [64];
  initial for (int i = 0; i < 64; i++) env_mem[i] = '0;
  always @(posedge clk) if (mem_write_o) env_mem[mem_address_o[7:2]] <= mem_write_data_o;
  assign mem_data_i = env_mem[mem_address_o[7:2]];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int write_cycles = 0;
  int exp_writes = 0;
  int idle_bus_viol = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_write_o) write_cycles++;
      if (!(mem_write_o || mem_read_o) && (mem_address_o != '0 || mem_write_data_o != '0))
        idle_bus_viol++;
      if (ack0_o) begin
        if (exp_q0.size() == 0) check("ack0 spurious", 32'(ack0_o), 32'd0);
        else begin
          exp_t e;
          e = exp_q0.pop_front();
          check("err0 on ack", 32'(err0_o), 32'(e.err));
          check("rdata0 on ack", rdata0_o, e.rdata);
        end
      end
      if (ack1_o) begin
        if (exp_q1.size() == 0) check("ack1 spurious", 32'(ack1_o), 32'd0);
        else begin
          exp_t e;
          e = exp_q1.pop_front();
          check("err1 on ack", 32'(err1_o), 32'(e.err));
          check("rdata1 on ack", rdata1_o, e.rdata);
        end
      end
    end
  end

  task automatic push_exp(input bit port, input logic err, input logic [DW-1:0] rd);
    exp_t e;
    e.err   = err;
    e.rdata = rd;
    if (port) exp_q1.push_back(e);
    else      exp_q0.push_back(e);
  endtask

  task automatic drop_reqs();
    req0_i = 1'b0; we0_i = 1'b0; addr0_i = '0; wdata0_i = '0;
    req1_i = 1'b0; we1_i = 1'b0; addr1_i = '0; wdata1_i = '0;
  endtask

  // One single-port transaction from IDLE; checks latency, memory-cycle count
  // and that the arbiter is back in IDLE right after the DONE cycle.
  task automatic do_txn(input string name, input bit port, input bit we,
                        input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic exp_err, input logic [DW-1:0] exp_rd);
    int  lat;
    int  memcyc;
    bit  got;
    bit  mis;
    mis = (addr[1:0] != 2'b00);
    push_exp(port, exp_err, exp_rd);
    if (we && !mis) exp_writes++;
    if (port) begin req1_i = 1'b1; we1_i = we; addr1_i = addr; wdata1_i = wdata; end
    else      begin req0_i = 1'b1; we0_i = we; addr0_i = addr; wdata0_i = wdata; end
    lat = 0; memcyc = 0; got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mem_write_o || mem_read_o) memcyc++;
      if (port ? ack1_o : ack0_o) got = 1'b1;
    end
    check({name, " ack seen"}, 32'(got), 32'd1);
    check({name, " latency"}, 32'(lat), mis ? 32'd1 : 32'd2);
    check({name, " memory cycles"}, 32'(memcyc), mis ? 32'd0 : 32'd1);
    // req stays high through DONE and drops in the cycle after the ack
    @(posedge clk);
    #1 drop_reqs();
    @(negedge clk);
    check({name, " idle after done"}, 32'(busy_o), 32'd0);
  endtask

  // Both ports request continuously; port 0 reads 0x08, port 1 reads a1.
  task automatic run_both(input string name, input logic [DW-1:0] a1,
                          input logic e_err1, input logic [DW-1:0] e_rd1);
    logic [9:0] order;
    bit         mis1;
    int         nack;
    int         last;
    order = 10'b10_0001_0000;  // grant i from port order[i]: 0,0,0,0,1,0,0,0,0,1
    mis1  = (a1[1:0] != 2'b00);
    for (int i = 0; i < 8; i++) push_exp(1'b0, 1'b0, 32'h12345678);
    for (int i = 0; i < 2; i++) push_exp(1'b1, e_err1, e_rd1);
    req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'h8;
    req1_i = 1'b1; we1_i = 1'b0; addr1_i = a1;
    nack = 0; last = 0;
    for (int i = 0; i < 60 && nack < 10; i++) begin
      @(negedge clk);
      if (ack0_o || ack1_o) begin
        check($sformatf("%s grant %0d port", name, nack), 32'(ack1_o), 32'(order[nack]));
        if (nack > 0)
          check($sformatf("%s grant %0d spacing", name, nack), 32'(cyc - last),
                (ack1_o && mis1) ? 32'd2 : 32'd3);
        last = cyc;
        nack++;
      end
    end
    check({name, " ack count"}, 32'(nack), 32'd10);
    @(posedge clk);
    #1 drop_reqs();
    @(negedge clk);
    check({name, " idle after run"}, 32'(busy_o), 32'd0);
  endtask

  typedef struct {
    bit            port;
    bit            we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //           port  we    addr           wdata          err   rdata
    vecs[0]  = '{1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF, 1'b0, 32'h00000000};
    vecs[1]  = '{1'b0, 1'b0, 32'h10010004, 32'h00000000, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 32'h10010006, 32'h00000000, 1'b1, 32'h00000000};
    vecs[3]  = '{1'b1, 1'b1, 32'h00000008, 32'h12345678, 1'b0, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b0, 32'h00000008, 32'h00000000, 1'b0, 32'h12345678};
    vecs[5]  = '{1'b1, 1'b1, 32'h00000020, 32'hCAFEF00D, 1'b0, 32'h00000000};
    vecs[6]  = '{1'b1, 1'b0, 32'h00000020, 32'h00000000, 1'b0, 32'hCAFEF00D};
    vecs[7]  = '{1'b0, 1'b1, 32'h0000000C, 32'h11112222, 1'b0, 32'h12345678};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000000C, 32'h00000000, 1'b0, 32'h11112222};
    vecs[9]  = '{1'b0, 1'b1, 32'h00000013, 32'h00000055, 1'b1, 32'h00000000};
    vecs[10] = '{1'b0, 1'b0, 32'h0000000C, 32'h00000000, 1'b0, 32'h11112222};
    vecs[11] = '{1'b1, 1'b0, 32'h00000008, 32'h00000000, 1'b0, 32'h12345678};

    drop_reqs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset acks/errs", {28'd0, ack0_o, err0_o, ack1_o, err1_o}, 32'd0);
    check("reset rdata0", rdata0_o, 32'd0);
    check("reset rdata1", rdata1_o, 32'd0);
    check("reset mem strobes", {30'd0, mem_write_o, mem_read_o}, 32'd0);
    check("reset mem address", mem_address_o, 32'd0);
    check("reset mem wdata", mem_write_data_o, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
             vecs[i].wdata, vecs[i].exp_err, vecs[i].exp_rd);

    // Starvation bound with an aligned, then a misaligned port-1 request.
    run_both("starve", 32'h00000020, 1'b0, 32'hCAFEF00D);
    run_both("starve_mis", 32'h10010006, 1'b1, 32'h00000000);

    // Reset during the ACCESS cycle of a port-0 write.
    @(posedge clk);
    #1;
    req0_i = 1'b1; we0_i = 1'b1; addr0_i = 32'h0000000C; wdata0_i = 32'hAAAA5555;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort in access", 32'(busy_o), 32'd1);
    check("abort write blocked", 32'(mem_write_o), 32'd0);
    check("abort address zero", mem_address_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drop_reqs();
    @(negedge clk);
    check("abort busy after reset", 32'(busy_o), 32'd0);
    check("abort no ack0", 32'(ack0_o), 32'd0);
    check("abort rdata0 cleared", rdata0_o, 32'd0);
    repeat (4) @(negedge clk);
    check("abort memory 0x0C kept", env_mem[3], 32'h11112222);
    do_txn("post-abort read", 1'b0, 1'b0, 32'h0000000C, 32'h0, 1'b0, 32'h11112222);

    repeat (3) @(negedge clk);
    check("port0 expectations drained", 32'(exp_q0.size()), 32'd0);
    check("port1 expectations drained", 32'(exp_q1.size()), 32'd0);
    check("write strobe cycles", 32'(write_cycles), 32'(exp_writes));
    check("idle bus is zero", 32'(idle_bus_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_arbiter.md
Name: data_memory_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single-port Data_Memory (synchronous write, combinational read).
- Port 0 is the CPU MEM stage and has priority. Port 1 is a secondary master (loader/DMA/debug).
- Each request is latched, driven onto the memory for exactly one cycle, and answered with a registered read-data and ack pulse.
- A starvation counter bounds how long port 1 can wait behind port 0.

Parameters:
- DATA_WIDTH, 32, width of data and address buses
- STARVE_LIMIT, 4, max consecutive port-0 grants while port 1 waits (legal range 1..15)

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- req0_i  in  1  port-0 request; held high until ack0_o
- we0_i  in  1  port-0 write (1) / read (0)
- addr0_i  in  DATA_WIDTH  port-0 byte address
- wdata0_i  in  DATA_WIDTH  port-0 write data
- ack0_o  out  1  port-0 one-cycle completion pulse
- err0_o  out  1  port-0 misaligned flag, valid with ack0_o
- rdata0_o  out  DATA_WIDTH  port-0 read data, valid with ack0_o
- req1_i, we1_i, addr1_i, wdata1_i, ack1_o, err1_o, rdata1_o: same as port 0, for port 1
- mem_address_o  out  DATA_WIDTH  to Data_Memory address_i
- mem_write_data_o  out  DATA_WIDTH  to write_data_i
- mem_write_o  out  1  to mem_write_i
- mem_read_o  out  1  to mem_read_i
- mem_data_i  in  DATA_WIDTH  from data_o
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, starve_cnt=0, sel=0.
  - Latched request registers are cleared.
  - All ack/err/rdata outputs are 0; all mem_* outputs are 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No requests: stay in IDLE.
  - Otherwise choose a winner:
    - Only req0: port 0.
    - Only req1: port 1.
    - Both: port 1 if starve_cnt==STARVE_LIMIT, else port 0.
  - Latch the winner's we/addr/wdata and sel.
  - Aligned address (addr[1:0]==0): go to ACCESS.
  - Misaligned address: go straight to DONE with err set, rdata=0, and no memory access.
- starve_cnt is updated on each grant:
  - Grant to 0 with req1 high: increment (saturates at STARVE_LIMIT).
  - Grant to 0 with req1 low, or any grant to 1: clear to 0.
  - Misaligned grants count normally.
- ACCESS (exactly one cycle):
  - mem_address_o = latched addr; mem_write_data_o = latched wdata.
  - mem_write_o = latched we & ~reset. No write commits in a reset cycle.
  - mem_read_o = ~latched we.
  - At the clock edge: the write commits in memory. For reads, rdataN_o <= mem_data_i for the selected port. Go to DONE.
- DONE (one cycle):
  - ack of the selected port = 1; err as latched.
  - mem_* = 0.
  - Requests are ignored this cycle; the requester's old req is still visible.
  - Next state: IDLE.
- Outside DONE, ack/err are 0.
- rdata of each port holds its last value until that port's next read or misaligned response.
  - A write ack leaves rdata unchanged.
- Latency: req seen in IDLE at edge N -> ACCESS during cycle N+1 -> ack during cycle N+2. Throughput is one transaction per 3 cycles.
- Requester rules:
  - Signals must stay stable from req rise until ack.
  - Deassert req, or present a new request, in the cycle after ack.
  - A req dropped before ack is still completed once granted.
- When mem_write_o/mem_read_o are low, mem_address_o and mem_write_data_o are 0.
- Reset mid-transaction: abort to IDLE, suppress the pending ack, and block the write in that cycle.
- STARVE_LIMIT outside 1..15 is a configuration error; a simulation $error is required at elaboration.

Test Plan:
- Port 0 write 0xDEADBEEF to 0x10010004, then read 0x10010004:
  - Write ack0 arrives 2 cycles after grant, rdata0 unchanged.
  - Read ack0 returns rdata0=0xDEADBEEF with err0=0.
  - mem_write_o is high for exactly 1 cycle.
- req0 and req1 held high continuously with STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1; no gap beyond 3 cycles per transaction.
- Port 1 read of 0x10010006 (misaligned) -> ack1 with err1=1 and rdata1=0; mem_read_o and mem_write_o never high; starve_cnt behaves as for a normal grant.
- Port 1 writes 0x12345678 to 0x08 while port 0 reads 0x08 immediately afterwards -> rdata0=0x12345678 (write committed before the later read); both acks seen once.
- Reset asserted during the ACCESS cycle of a port-0 write of 0xAAAA5555 to 0x0C -> mem_write_o=0 that cycle; memory word 0x0C keeps its prior value; no ack0; busy_o=0 the cycle after reset.
- req0 held through DONE without a new request intended -> exactly one ack per transaction; the next transaction does not start before IDLE.
